// File: rtl/prio_sel_pkg.sv
// prio_sel_pkg
// Shared definitions for the pipelined priority selector:
//   SEL_W        - width of a channel index ($clog2 with a floor of 1)
//   DEF_POL      - default per-condition polarity for the 6-channel build
//   DEF_LATE_MASK- default per-condition late-veto enables
//   prio_sel_idx - combinational priority pick over a condition chain
package prio_sel_pkg;

  // Widest condition chain prio_sel_idx can evaluate. Callers zero-extend
  // their chain into this width and pass the real channel count.
  localparam int MAX_COND = 31;

  localparam logic [4:0] DEF_POL       = 5'b01101;
  localparam logic [4:0] DEF_LATE_MASK = 5'b01000;

  function automatic int SEL_W(input int n_ch);
    return (n_ch < 2) ? 1 : $clog2(n_ch);
  endfunction

  // Lowest chain position whose condition holds wins; when none holds the
  // last channel (n_ch-1) is the fallback. Positions >= n_ch-1 are ignored
  // so zero-extension of the inputs cannot create phantom matches.
  function automatic int prio_sel_idx(
    input logic [MAX_COND-1:0] cond,
    input logic [MAX_COND-1:0] pol,
    input logic [MAX_COND-1:0] mask,
    input logic                late,
    input int                  n_ch
  );
    int idx;
    idx = n_ch - 1;
    // Scan downwards so the last assignment is the lowest true position.
    for (int k = MAX_COND - 1; k >= 0; k--) begin
      if ((k < n_ch - 1) && (cond[k] == pol[k]) && !(mask[k] && late)) begin
        idx = k;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_sel_pipe_if.sv
// prio_sel_pipe_if
// Bundles the selector's input beat, output beat and counter control.
//   in_valid/in_ready/in_data/in_cond/late_ctrl : upstream handshake + payload
//   out_valid/out_ready/out_data/out_sel        : downstream handshake + result
//   fallback_cnt/cnt_clr                        : fallback statistics
// Modports: slave = the selector's view, master = the driving environment.
interface prio_sel_pipe_if #(
  parameter int N_CH   = 6,
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
);
  import prio_sel_pkg::*;

  localparam int SW = SEL_W(N_CH);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-2:0]          in_cond;
  logic                     late_ctrl;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SW-1:0]            out_sel;
  logic [CNT_W-1:0]         fallback_cnt;
  logic                     cnt_clr;

  modport slave (
    input  in_valid, in_data, in_cond, late_ctrl, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_sel, fallback_cnt
  );

  modport master (
    output in_valid, in_data, in_cond, late_ctrl, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_sel, fallback_cnt
  );

endinterface

// File: rtl/prio_sel_skid.sv
// prio_sel_skid
// Generic 2-entry valid/ready skid buffer, FIFO order.
//   in_valid/in_ready/in_payload    : upstream side; in_ready is registered
//   out_valid/out_ready/out_payload : downstream side; payload is the head
// A beat pushed into an empty buffer is visible at the output next cycle.
module prio_sel_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  always_comb begin
    push       = in_valid && in_ready_q;
    pop        = (count_q != 2'd0) && out_ready;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_payload;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        // Push and pop together: the new beat replaces the departing head.
        if (push && pop) begin
          head_d = in_payload;
        end else if (push) begin
          tail_d  = in_payload;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // Full: in_ready_q is low, so only a pop can happen.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_payload = head_q;

endmodule

// File: rtl/prio_sel_pipe.sv
// prio_sel_pipe
// Pipelined priority selector. Each accepted beat picks one of N_CH data
// candidates from a polarity-configurable condition chain (with optional
// late_ctrl veto per position), and the chosen data + index travel through
// a 2-entry skid buffer to the output. A saturating counter tracks beats
// that fell through to the last channel.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : prio_sel_pipe_if.slave (handshakes, payload, counter)
module prio_sel_pipe
  import prio_sel_pkg::*;
#(
  parameter int N_CH      = 6,
  parameter int DATA_W    = 1,
  parameter     POL       = DEF_POL,
  parameter     LATE_MASK = DEF_LATE_MASK,
  parameter int CNT_W     = 8
) (
  input logic             clk,
  input logic             rst_n,
  prio_sel_pipe_if.slave  bus
);

  localparam int SW = SEL_W(N_CH);
  localparam int PW = DATA_W + SW;

  // Elaboration-time sanity checks on the parameter set.
  if (N_CH < 2 || N_CH - 1 > MAX_COND) begin : g_bad_nch
    $error("prio_sel_pipe: N_CH out of range");
  end
  if ($bits(POL) != N_CH - 1) begin : g_bad_pol
    $error("prio_sel_pipe: POL width must be N_CH-1");
  end
  if ($bits(LATE_MASK) != N_CH - 1) begin : g_bad_mask
    $error("prio_sel_pipe: LATE_MASK width must be N_CH-1");
  end

  logic [DATA_W-1:0] cand [N_CH];
  logic [SW-1:0]     sel_idx;
  logic [DATA_W-1:0] sel_data;
  logic              push;
  logic              fb_push;
  logic [PW-1:0]     skid_out;
  logic [CNT_W-1:0]  fallback_cnt_q, fallback_cnt_d;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
    assign cand[gi] = bus.in_data[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    sel_idx  = SW'(prio_sel_idx(MAX_COND'(bus.in_cond), MAX_COND'(POL),
                                MAX_COND'(LATE_MASK), bus.late_ctrl, N_CH));
    sel_data = cand[sel_idx];
  end

  prio_sel_skid #(.W(PW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .in_payload  ({sel_data, sel_idx}),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready),
    .out_payload (skid_out)
  );

  assign bus.out_data = skid_out[PW-1:SW];
  assign bus.out_sel  = skid_out[SW-1:0];

  // Counter follows accepted beats only; a clear in the same cycle wins.
  always_comb begin
    push           = bus.in_valid && bus.in_ready;
    fb_push        = push && (sel_idx == SW'(N_CH - 1));
    fallback_cnt_d = fallback_cnt_q;
    if (bus.cnt_clr) begin
      fallback_cnt_d = '0;
    end else if (fb_push && (fallback_cnt_q != {CNT_W{1'b1}})) begin
      fallback_cnt_d = fallback_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fallback_cnt_q <= '0;
    end else begin
      fallback_cnt_q <= fallback_cnt_d;
    end
  end

  assign bus.fallback_cnt = fallback_cnt_q;

endmodule

// File: tb/tb_prio_sel_pipe.sv
// tb_prio_sel_pipe
// Table-driven and randomized bench for prio_sel_pipe (N_CH=6, DATA_W=8,
// CNT_W=2). A queue-based reference model tracks buffered beats and the
// fallback counter; outputs are sampled 1 time unit after each rising edge.
module tb_prio_sel_pipe;

  localparam int N_CH   = 6;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam logic [4:0] POL   = 5'b01101;
  localparam logic [4:0] LMASK = 5'b01000;
  localparam int CNT_MAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_sel_pipe_if #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  prio_sel_pipe #(
    .N_CH(N_CH), .DATA_W(DATA_W), .POL(5'b01101), .LATE_MASK(5'b01000), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    int         s;
  } beat_t;

  typedef struct {
    logic [4:0] cond;
    logic       late;
    int         exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  beat_t q[$];
  int    cnt_m = 0;
  vec_t  vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference selection straight from the rule: first true condition wins,
  // otherwise the last channel.
  function automatic int ref_sel(input logic [4:0] c, input logic late);
    for (int k = 0; k < N_CH - 1; k++) begin
      if ((c[k] == POL[k]) && !(LMASK[k] && late)) return k;
    end
    return N_CH - 1;
  endfunction

  function automatic logic [47:0] a_data();
    logic [47:0] d;
    for (int k = 0; k < N_CH; k++) d[k*8 +: 8] = 8'h10 + 8'(k);
    return d;
  endfunction

  function automatic logic [47:0] rnd_data();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic check_model();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_sel", 32'(bus.out_sel), 32'(q[0].s));
      chk("out_data", 32'(bus.out_data), 32'(q[0].d));
    end
    chk("fallback_cnt", 32'(bus.fallback_cnt), 32'(cnt_m));
  endtask

  // One clock: drive inputs, predict push/pop, advance, update model, compare.
  task automatic cycle(input logic v, input logic [4:0] c, input logic late,
                       input logic [47:0] d, input logic ordy, input logic clr);
    bit push, pop;
    int s;
    bus.in_valid  = v;
    bus.in_cond   = c;
    bus.late_ctrl = late;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.cnt_clr   = clr;
    s    = ref_sel(c, late);
    push = v && (q.size() < 2);
    pop  = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{d: d[s*8 +: 8], s: s});
    if (clr) cnt_m = 0;
    else if (push && s == N_CH - 1 && cnt_m < CNT_MAX) cnt_m++;
    $display("cyc t=%0t v=%0b cond=%b late=%0b ordy=%0b clr=%0b -> ov=%0b ir=%0b sel=%0d data=%02h cnt=%0d",
             $time, v, c, late, ordy, clr, bus.out_valid, bus.in_ready,
             bus.out_sel, bus.out_data, bus.fallback_cnt);
    check_model();
  endtask

  initial begin
    vecs[0] = '{5'b00001, 1'b0, 0, 8'h10};
    vecs[1] = '{5'b00000, 1'b0, 1, 8'h11};
    vecs[2] = '{5'b00110, 1'b0, 2, 8'h12};
    vecs[3] = '{5'b01010, 1'b0, 3, 8'h13};
    vecs[4] = '{5'b01010, 1'b1, 4, 8'h14};
    vecs[5] = '{5'b10010, 1'b0, 5, 8'h15};
    vecs[6] = '{5'b11111, 1'b0, 0, 8'h10};
    vecs[7] = '{5'b11010, 1'b1, 5, 8'h15};

    bus.in_valid  = 1'b0;
    bus.in_cond   = '0;
    bus.late_ctrl = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.cnt_clr   = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_fallback_cnt", 32'(bus.fallback_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Priority / polarity / late veto table
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vecs[i].cond, vecs[i].late, a_data(), 1'b1, 1'b0);
      chk("vec_sel", 32'(bus.out_sel), 32'(vecs[i].exp_sel));
      chk("vec_data", 32'(bus.out_data), 32'(vecs[i].exp_data));
    end
    chk("fb_after_table", 32'(bus.fallback_cnt), 32'd2);

    // Saturation, then clear colliding with a fallback push
    for (int i = 0; i < 5; i++) cycle(1'b1, 5'b10010, 1'b0, a_data(), 1'b1, 1'b0);
    chk("fb_saturated", 32'(bus.fallback_cnt), 32'd3);
    cycle(1'b1, 5'b10010, 1'b0, a_data(), 1'b1, 1'b1);
    chk("fb_clear_wins", 32'(bus.fallback_cnt), 32'd0);
    cycle(1'b1, 5'b10010, 1'b0, a_data(), 1'b1, 1'b0);
    chk("fb_after_clear", 32'(bus.fallback_cnt), 32'd1);
    cycle(1'b0, 5'b00000, 1'b0, a_data(), 1'b1, 1'b0);

    // Backpressure: sel 0,1 accepted, sel 2 held upstream
    cycle(1'b1, 5'b00001, 1'b0, a_data(), 1'b0, 1'b0);
    cycle(1'b1, 5'b00000, 1'b0, a_data(), 1'b0, 1'b0);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, 5'b00110, 1'b0, a_data(), 1'b0, 1'b0);
    chk("bp_hold_sel", 32'(bus.out_sel), 32'd0);
    chk("bp_hold_data", 32'(bus.out_data), 32'h10);
    cycle(1'b1, 5'b00110, 1'b0, a_data(), 1'b1, 1'b0);
    chk("bp_order1", 32'(bus.out_sel), 32'd1);
    cycle(1'b1, 5'b00110, 1'b0, a_data(), 1'b1, 1'b0);
    chk("bp_order2", 32'(bus.out_sel), 32'd2);
    cycle(1'b0, 5'b00000, 1'b0, a_data(), 1'b1, 1'b0);

    // Concurrent push/pop at count=1: one beat per cycle
    cycle(1'b1, 5'($urandom), 1'($urandom), rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 5'($urandom), 1'($urandom), rnd_data(), 1'b1, 1'b0);
      chk("tput_out_valid", 32'(bus.out_valid), 32'd1);
      chk("tput_in_ready", 32'(bus.in_ready), 32'd1);
    end

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom), 5'($urandom), 1'($urandom), rnd_data(),
            1'($urandom), ($urandom_range(15) == 0));
    end

    // Reset mid-operation with two fallback beats buffered
    cycle(1'b0, 5'b00000, 1'b0, a_data(), 1'b1, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0, a_data(), 1'b1, 1'b0);
    cycle(1'b1, 5'b10010, 1'b0, a_data(), 1'b0, 1'b0);
    cycle(1'b1, 5'b10010, 1'b0, a_data(), 1'b0, 1'b0);
    chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_fallback_cnt", 32'(bus.fallback_cnt), 32'd0);
    chk("mid_rst_out_sel", 32'(bus.out_sel), 32'd0);
    q.delete();
    cnt_m = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 5'b00000, 1'b0, a_data(), 1'b1, 1'b0);
    cycle(1'b1, 5'b00110, 1'b0, a_data(), 1'b1, 1'b0);
    chk("post_rst_sel", 32'(bus.out_sel), 32'd2);
    cycle(1'b0, 5'b00000, 1'b0, a_data(), 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
